mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of address, read data and write data.
REQ-002 Parameter MAX_STREAK, 4, number of consecutive LSU grants after which a waiting IFU request wins (range 1..15).
REQ-003 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Ports if_valid, if_addr  input  1, DATA_WIDTH  instruction-fetch request and its address (read-only requester).
REQ-006 Ports if_ready, if_rvalid, if_rdata  output  1, 1, DATA_WIDTH  IFU request accept, response strobe, response data.
REQ-007 Ports ls_valid, ls_addr, ls_wen, ls_wdata, ls_wmask  input  1, DATA_WIDTH, 1, DATA_WIDTH, 4  load/store request.
REQ-008 Ports ls_ready, ls_rvalid, ls_rdata  output  1, 1, DATA_WIDTH  LSU request accept, response strobe, response data.
REQ-009 Ports mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask  output  1, DATA_WIDTH, 1, DATA_WIDTH, 4  request to the shared memory.
REQ-010 Ports mem_ready, mem_rvalid, mem_rdata  input  1, 1, DATA_WIDTH  memory accept, response strobe (reads and write-acks), read data.
REQ-011 Ports busy, grant_ls  output  1, 1  transaction in flight; current/last owner (1 = LSU).

Function
REQ-012 State machine SHALL have states IDLE, REQ, RESP; reset state IDLE.
REQ-013 IDLE: if no requester valid, stay IDLE; otherwise select one requester, assert its *_ready for that cycle only, latch addr/wen/wdata/wmask (IFU: wen=0, wmask=0), go to REQ.
REQ-014 Selection: LSU wins when both valid, except IFU wins when both valid and streak counter equals MAX_STREAK.
REQ-015 Streak counter: +1 on each LSU grant while if_valid=1; cleared on any IFU grant and in any cycle with if_valid=0; saturates at MAX_STREAK.
REQ-016 *_ready SHALL be 0 in REQ and RESP; a requester not granted keeps its request pending (requester holds valid/fields).
REQ-017 REQ: mem_valid=1 with latched fields held stable; on mem_ready=1 go to RESP; otherwise stay.
REQ-018 RESP: mem_valid=0; on mem_rvalid=1 assert owner's *_rvalid for exactly that cycle with *_rdata=mem_rdata (combinational pass-through, zero added latency), go to IDLE.
REQ-019 Non-owner *_rvalid SHALL be 0 at all times; *_rdata of non-owner SHALL be 0.
REQ-020 mem_rvalid in IDLE or REQ (including same cycle as mem_ready) SHALL be ignored; response accepted only in RESP.
REQ-021 Minimum transaction = 3 cycles (IDLE accept, REQ with mem_ready=1, RESP with mem_rvalid=1); no overlap of transactions.
REQ-022 No timeout: REQ/RESP wait indefinitely for mem_ready/mem_rvalid.
REQ-023 busy=1 in REQ and RESP, 0 in IDLE; grant_ls updated at grant, held otherwise.
REQ-024 mem_addr/mem_wdata/mem_wmask/mem_wen SHALL be 0 when mem_valid=0.

Reset
REQ-025 rst=1 at posedge: state IDLE, streak 0, grant_ls 0, latched fields 0.
REQ-026 While in reset and the cycle after: all outputs 0 (mem_valid, *_ready, *_rvalid, busy, data buses).
REQ-027 Reset mid-transaction SHALL abandon it silently: no *_rvalid issued for it; a late mem_rvalid after reset is ignored per REQ-020.

Verification
REQ-028 IFU only, if_addr=0x80000000, mem_ready=1 immediately, mem_rvalid next cycle with rdata=0x00000413 -> if_ready in cycle 0, mem_valid cycle 1, if_rvalid with 0x00000413 cycle 2, ls_rvalid never.
REQ-029 Both valid in IDLE, streak 0 -> LSU granted; mem_wen/mem_wdata/mem_wmask match ls fields (e.g. 0xDEADBEEF, mask 0xF); IFU granted on next IDLE if LSU drops valid.
REQ-030 Both valid continuously, MAX_STREAK=4 -> grant sequence LSU,LSU,LSU,LSU,IFU,LSU...
REQ-031 mem_ready held 0 for 5 cycles in REQ -> mem_valid and fields stable all 5 cycles, no *_ready, busy=1.
REQ-032 Stray mem_rvalid=1 in IDLE and in REQ -> no *_rvalid; rst asserted in RESP then mem_rvalid -> no *_rvalid, state IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (IFU read-only, LSU read/write) arbiter onto a
// single shared memory port. One transaction at a time, in three phases:
// IDLE (accept), REQ (present to memory), RESP (wait for response).
// The LSU has priority, but after MAX_STREAK back-to-back LSU grants a
// waiting IFU request is served next.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   if_valid/if_addr               IFU request in
//   if_ready/if_rvalid/if_rdata    IFU accept, response strobe and data
//   ls_valid/ls_addr/ls_wen/
//   ls_wdata/ls_wmask              LSU request in
//   ls_ready/ls_rvalid/ls_rdata    LSU accept, response strobe and data
//   mem_valid/mem_addr/mem_wen/
//   mem_wdata/mem_wmask            request to shared memory
//   mem_ready/mem_rvalid/mem_rdata memory accept, response strobe and data
//   busy                           transaction in flight
//   grant_ls                       current/last owner (1 = LSU)
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [DATA_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ls_valid,
  input  logic [DATA_WIDTH-1:0] ls_addr,
  input  logic                  ls_wen,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  input  logic [3:0]            ls_wmask,
  output logic                  ls_ready,
  output logic                  ls_rvalid,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  mem_valid,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  grant_ls
);

  localparam int unsigned STREAK_W = 4;
  localparam int unsigned MASK_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_rst_d;
  logic [STREAK_W-1:0]   r_streak;
  logic                  r_grant_ls;
  logic [DATA_WIDTH-1:0] r_addr;
  logic                  r_wen;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [MASK_W-1:0]     r_wmask;

  logic w_block;
  logic w_streak_max;
  logic w_grant_if;
  logic w_grant_ls;

  // Outputs are forced quiet during reset and the cycle right after it.
  assign w_block      = rst | r_rst_d;
  assign w_streak_max = (r_streak == STREAK_W'(MAX_STREAK));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Reset-shadow flag
  always_ff @(posedge clk) begin
    r_rst_d <= rst;
  end

  // Next-state, grant and handshake strobes
  always_comb begin
    w_state_next = r_state;
    w_grant_if   = 1'b0;
    w_grant_ls   = 1'b0;
    if_ready     = 1'b0;
    ls_ready     = 1'b0;
    if_rvalid    = 1'b0;
    ls_rvalid    = 1'b0;
    mem_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_block) begin
          // LSU first, unless the IFU has been starved for MAX_STREAK grants
          if (ls_valid && !(if_valid && w_streak_max)) w_grant_ls = 1'b1;
          else if (if_valid)                           w_grant_if = 1'b1;
        end
        if_ready = w_grant_if;
        ls_ready = w_grant_ls;
        if (w_grant_if || w_grant_ls) w_state_next = REQ;
      end
      REQ: begin
        busy      = 1'b1;
        mem_valid = 1'b1;
        if (mem_ready) w_state_next = RESP;
      end
      RESP: begin
        busy = 1'b1;
        if (mem_rvalid) begin
          ls_rvalid    = r_grant_ls;
          if_rvalid    = ~r_grant_ls;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (w_block) begin
      if_ready  = 1'b0;
      ls_ready  = 1'b0;
      if_rvalid = 1'b0;
      ls_rvalid = 1'b0;
      mem_valid = 1'b0;
      busy      = 1'b0;
    end
  end

  // Latched request fields, owner and starvation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_wen      <= 1'b0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_grant_ls <= 1'b0;
      r_streak   <= '0;
    end else begin
      if (w_grant_ls) begin
        r_addr     <= ls_addr;
        r_wen      <= ls_wen;
        r_wdata    <= ls_wdata;
        r_wmask    <= ls_wmask;
        r_grant_ls <= 1'b1;
      end else if (w_grant_if) begin
        r_addr     <= if_addr;
        r_wen      <= 1'b0;
        r_wdata    <= '0;
        r_wmask    <= '0;
        r_grant_ls <= 1'b0;
      end
      // Count only LSU grants that actually made a waiting IFU wait
      if (!if_valid || w_grant_if)        r_streak <= '0;
      else if (w_grant_ls && !w_streak_max) r_streak <= r_streak + STREAK_W'(1);
    end
  end

  // Memory-side fields are zero whenever no request is presented
  assign mem_addr  = mem_valid ? r_addr  : '0;
  assign mem_wen   = mem_valid & r_wen;
  assign mem_wdata = mem_valid ? r_wdata : '0;
  assign mem_wmask = mem_valid ? r_wmask : '0;

  // Response data passes straight through to the owner only
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign ls_rdata  = ls_rvalid ? mem_rdata : '0;
  assign grant_ls  = r_grant_ls & ~w_block;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter: one vector per clock cycle,
// inputs driven on the falling edge and all outputs compared 1 time unit later.
module tb_mem_arbiter;

  localparam int unsigned DW = 32;

  typedef struct packed {
    logic          rst;
    logic          if_valid;
    logic [DW-1:0] if_addr;
    logic          ls_valid;
    logic [DW-1:0] ls_addr;
    logic          ls_wen;
    logic [DW-1:0] ls_wdata;
    logic [3:0]    ls_wmask;
    logic          mem_ready;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
  } in_t;

  typedef struct packed {
    logic          if_ready;
    logic          ls_ready;
    logic          if_rvalid;
    logic          ls_rvalid;
    logic [DW-1:0] if_rdata;
    logic [DW-1:0] ls_rdata;
    logic          mem_valid;
    logic [DW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_wmask;
    logic          busy;
    logic          grant_ls;
  } out_t;

  typedef struct {
    in_t  vin;
    out_t vexp;
  } vec_t;

  localparam logic [DW-1:0] IA  = 32'h8000_0000;
  localparam logic [DW-1:0] LA  = 32'h0000_1000;
  localparam logic [DW-1:0] WD  = 32'hDEAD_BEEF;
  localparam logic [DW-1:0] RD  = 32'h0000_0413;
  localparam logic [DW-1:0] LRD = 32'hCAFE_0001;
  localparam logic [DW-1:0] LA2 = 32'h0000_2000;
  localparam logic [DW-1:0] WD2 = 32'h0BAD_F00D;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_valid;
  logic [DW-1:0] if_addr;
  logic          if_ready;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ls_valid;
  logic [DW-1:0] ls_addr;
  logic          ls_wen;
  logic [DW-1:0] ls_wdata;
  logic [3:0]    ls_wmask;
  logic          ls_ready;
  logic          ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          mem_valid;
  logic [DW-1:0] mem_addr;
  logic          mem_wen;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wmask;
  logic          mem_ready;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          grant_ls;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(DW), .MAX_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_addr(if_addr),
    .if_ready(if_ready), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_valid(ls_valid), .ls_addr(ls_addr), .ls_wen(ls_wen),
    .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_ready(ls_ready), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .grant_ls(grant_ls)
  );

  function automatic in_t mi(logic r, logic ifv, logic [DW-1:0] ifa,
                             logic lsv, logic [DW-1:0] lsa, logic wen,
                             logic [DW-1:0] wd, logic [3:0] wm,
                             logic mr, logic mrv, logic [DW-1:0] mrd);
    in_t v;
    v.rst = r; v.if_valid = ifv; v.if_addr = ifa;
    v.ls_valid = lsv; v.ls_addr = lsa; v.ls_wen = wen;
    v.ls_wdata = wd; v.ls_wmask = wm;
    v.mem_ready = mr; v.mem_rvalid = mrv; v.mem_rdata = mrd;
    return v;
  endfunction

  function automatic out_t mo(logic ifr, logic lsr, logic ifrv, logic lsrv,
                              logic [DW-1:0] ifrd, logic [DW-1:0] lsrd,
                              logic mv, logic [DW-1:0] ma, logic mw,
                              logic [DW-1:0] mwd, logic [3:0] mwm,
                              logic b, logic g);
    out_t o;
    o.if_ready = ifr; o.ls_ready = lsr; o.if_rvalid = ifrv; o.ls_rvalid = lsrv;
    o.if_rdata = ifrd; o.ls_rdata = lsrd; o.mem_valid = mv; o.mem_addr = ma;
    o.mem_wen = mw; o.mem_wdata = mwd; o.mem_wmask = mwm; o.busy = b;
    o.grant_ls = g;
    return o;
  endfunction

  task automatic add(input in_t vi, input out_t vo);
    vec_t v;
    v.vin  = vi;
    v.vexp = vo;
    vecs.push_back(v);
  endtask

  task automatic step(input in_t vi, input out_t eo, input string nm);
    out_t act;
    @(negedge clk);
    rst = vi.rst; if_valid = vi.if_valid; if_addr = vi.if_addr;
    ls_valid = vi.ls_valid; ls_addr = vi.ls_addr; ls_wen = vi.ls_wen;
    ls_wdata = vi.ls_wdata; ls_wmask = vi.ls_wmask;
    mem_ready = vi.mem_ready; mem_rvalid = vi.mem_rvalid;
    mem_rdata = vi.mem_rdata;
    #1;
    act = mo(if_ready, ls_ready, if_rvalid, ls_rvalid, if_rdata, ls_rdata,
             mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, busy, grant_ls);
    checks++;
    if (act !== eo) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, eo);
    end
  endtask

  initial begin
    out_t z;
    logic prev_ls;
    z = '0;
    rst = 1'b1; if_valid = 1'b0; if_addr = '0; ls_valid = 1'b0; ls_addr = '0;
    ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0; mem_ready = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset, post-reset quiet cycle, IFU read, LSU write, IFU after LSU drops
    add(mi(1, 1, IA, 1, LA, 1, WD, 4'hF, 1, 1, RD), z);
    add(mi(1, 1, IA, 0, 0, 0, 0, 0, 0, 0, 0), z);
    add(mi(0, 1, IA, 0, 0, 0, 0, 0, 0, 0, 0), z);
    add(mi(0, 1, IA, 0, 0, 0, 0, 0, 1, 0, 0),
        mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h55),
        mo(0, 0, 0, 0, 0, 0, 1, IA, 0, 0, 0, 1, 0));
    add(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, RD),
        mo(0, 0, 1, 0, RD, 0, 0, 0, 0, 0, 0, 1, 0));
    add(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77), z);
    add(mi(0, 1, IA, 1, LA, 1, WD, 4'hF, 0, 0, 0),
        mo(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mi(0, 1, IA, 0, 0, 0, 0, 0, 0, 0, 0),
        mo(0, 0, 0, 0, 0, 0, 1, LA, 1, WD, 4'hF, 1, 1));
    add(mi(0, 1, IA, 0, 0, 0, 0, 0, 1, 0, 0),
        mo(0, 0, 0, 0, 0, 0, 1, LA, 1, WD, 4'hF, 1, 1));
    add(mi(0, 1, IA, 0, 0, 0, 0, 0, 0, 0, 0),
        mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    add(mi(0, 1, IA, 0, 0, 0, 0, 0, 0, 1, LRD),
        mo(0, 0, 0, 1, 0, LRD, 0, 0, 0, 0, 0, 1, 1));
    add(mi(0, 1, IA, 0, 0, 0, 0, 0, 0, 0, 0),
        mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add(mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0),
        mo(0, 0, 0, 0, 0, 0, 1, IA, 0, 0, 0, 1, 0));
    add(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, RD),
        mo(0, 0, 1, 0, RD, 0, 0, 0, 0, 0, 0, 1, 0));

    for (int k = 0; k < vecs.size(); k++)
      step(vecs[k].vin, vecs[k].vexp, $sformatf("vec%0d", k));

    // Both requesters always valid: LSU x4, then IFU, then LSU again
    prev_ls = 1'b0;
    for (int g = 0; g < 6; g++) begin
      logic lsu;
      in_t  vi;
      lsu = (g != 4);
      vi  = mi(0, 1, IA, 1, LA, 1, WD, 4'hF, 1, 1, RD);
      step(vi, mo(~lsu, lsu, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, prev_ls),
           $sformatf("streak_grant%0d", g));
      step(vi, mo(0, 0, 0, 0, 0, 0, 1, lsu ? LA : IA, lsu, lsu ? WD : '0,
                  lsu ? 4'hF : 4'h0, 1, lsu),
           $sformatf("streak_req%0d", g));
      step(vi, mo(0, 0, ~lsu, lsu, lsu ? '0 : RD, lsu ? RD : '0,
                  0, 0, 0, 0, 0, 1, lsu),
           $sformatf("streak_resp%0d", g));
      prev_ls = lsu;
    end

    // Memory stalls 5 cycles in REQ with stray responses and pending requests
    step(mi(0, 0, 0, 1, LA2, 1, WD2, 4'h3, 0, 0, 0),
         mo(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "stall_grant");
    for (int s = 0; s < 5; s++)
      step(mi(0, 1, IA, 1, LA, 0, WD, 4'hF, 0, 1, RD),
           mo(0, 0, 0, 0, 0, 0, 1, LA2, 1, WD2, 4'h3, 1, 1),
           $sformatf("stall%0d", s));
    step(mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0),
         mo(0, 0, 0, 0, 0, 0, 1, LA2, 1, WD2, 4'h3, 1, 1), "stall_accept");
    step(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234),
         mo(0, 0, 0, 1, 0, 32'h1234, 0, 0, 0, 0, 0, 1, 1), "stall_resp");

    // Reset while waiting for the response abandons the transaction
    step(mi(0, 1, IA, 0, 0, 0, 0, 0, 0, 0, 0),
         mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "rr_grant");
    step(mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0),
         mo(0, 0, 0, 0, 0, 0, 1, IA, 0, 0, 0, 1, 0), "rr_req");
    step(mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, RD), z, "rr_rst_in_resp");
    step(mi(0, 1, IA, 0, 0, 0, 0, 0, 0, 1, RD), z, "rr_late_rvalid");
    step(mi(0, 1, IA, 0, 0, 0, 0, 0, 0, 0, 0),
         mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rr_idle_grant");
    step(mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, RD),
         mo(0, 0, 0, 0, 0, 0, 1, IA, 0, 0, 0, 1, 0), "rr_req2");
    step(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, RD),
         mo(0, 0, 1, 0, RD, 0, 0, 0, 0, 0, 0, 1, 0), "rr_resp2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
